// File: rtl/instructmem_pipelined.sv
// -----------------------------------------------------------------------------
// instructmem_pipelined
//   Instruction ROM for a pipelined CPU fetch stage. PC-indexed requests
//   arrive over a valid/ready port. Each request passes through a
//   READ_LAT-deep read pipeline into an in-order response FIFO. A
//   credit-based req_ready guarantees that every accepted request has a FIFO
//   slot reserved, so the pipeline never stalls and never drops a response.
//   A misaligned or out-of-range fetch does not index the memory. It returns
//   rsp_err=1 with rsp_instr=0 in its normal response slot.
//
//   The program image is written word by word through the prog_* port.
//   Loading from a file is not supported in this build. A non-empty
//   INIT_FILE stops elaboration so that a missing image cannot go unnoticed.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high; clears control state, not memory
//   req_valid  in   fetch request present
//   req_ready  out  a request can be accepted this cycle
//   req_addr   in   64-bit byte address of the instruction
//   rsp_valid  out  FIFO head holds a response
//   rsp_ready  in   consumer takes the head response this cycle
//   rsp_instr  out  fetched word (0 on error or when no response is valid)
//   rsp_err    out  head response was misaligned or out of range
//   prog_we    in   program-load word write enable
//   prog_addr  in   byte address of the word to write (low 2 bits ignored)
//   prog_data  in   word to write
//   fetch_cnt  out  accepted requests since reset; saturating
// -----------------------------------------------------------------------------
module instructmem_pipelined #(
    parameter int    MEM_BYTES = 1024,
    parameter int    INSTR_W   = 32,
    parameter int    READ_LAT  = 1,
    parameter int    RSP_DEPTH = 2,
    parameter string INIT_FILE = ""
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [63:0]        req_addr,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [INSTR_W-1:0] rsp_instr,
    output logic               rsp_err,
    input  logic               prog_we,
    input  logic [63:0]        prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    output logic [31:0]        fetch_cnt
);

    localparam int WORDS = MEM_BYTES / 4;
    localparam int AW    = $clog2(WORDS);
    localparam int PW    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW    = $clog2(RSP_DEPTH + 1);
    localparam int OW    = $clog2(READ_LAT + RSP_DEPTH + 1) + 1;

    // Elaboration-time parameter checks
    if (MEM_BYTES <= 4 || (MEM_BYTES & (MEM_BYTES - 1)) != 0) begin : g_bad_mem_bytes
        $error("MEM_BYTES must be a power of two greater than 4");
    end
    if (INSTR_W != 32) begin : g_bad_instr_w
        $error("INSTR_W must be 32");
    end
    if (READ_LAT < 1 || READ_LAT > 3) begin : g_bad_read_lat
        $error("READ_LAT must be 1..3");
    end
    if (RSP_DEPTH < 1) begin : g_bad_rsp_depth
        $error("RSP_DEPTH must be at least 1");
    end
    if (INIT_FILE != "") begin : g_bad_init_file
        $error("INIT_FILE is not supported; load the program through the prog port");
    end

    logic [INSTR_W-1:0] mem_r [WORDS];

    logic               ready_r;
    logic               accept_s;
    logic               req_err_s;
    logic [AW-1:0]      rd_idx_s;
    logic [AW-1:0]      wr_idx_s;
    logic               prog_ok_s;

    logic [READ_LAT-1:0] pv_r;
    logic [READ_LAT-1:0] pe_r;
    logic [INSTR_W-1:0]  pd_r [READ_LAT];

    logic [INSTR_W-1:0]  fd_r [RSP_DEPTH];
    logic [RSP_DEPTH-1:0] fe_r;
    logic [PW-1:0]       wr_ptr_r;
    logic [PW-1:0]       rd_ptr_r;
    logic [CW-1:0]       count_r;
    logic [CW-1:0]       count_next_s;
    logic [OW-1:0]       occ_next_s;
    logic                push_s;
    logic                pop_s;
    logic                rsp_valid_s;
    logic [31:0]         fetch_cnt_r;

    // Wrap-around FIFO pointer increment (depth need not be a power of two)
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(RSP_DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign accept_s    = req_valid && ready_r;
    // addr+3 >= MEM_BYTES rewritten as a compare that cannot overflow
    assign req_err_s   = (req_addr[1:0] != 2'b00) || (req_addr >= 64'(MEM_BYTES - 3));
    assign rd_idx_s    = req_addr[AW+1:2];
    assign wr_idx_s    = prog_addr[AW+1:2];
    assign prog_ok_s   = prog_addr < 64'(MEM_BYTES);
    assign push_s      = pv_r[READ_LAT-1];
    assign rsp_valid_s = count_r != CW'(0);
    assign pop_s       = rsp_ready && rsp_valid_s;

    // Program-load write port; memory is deliberately outside the reset domain
    always_ff @(posedge clk) begin
        if (prog_we && prog_ok_s) begin
            mem_r[wr_idx_s] <= prog_data;
        end
    end

    // Read pipeline datapath: stage 0 reads memory (old data on a same-edge write)
    always_ff @(posedge clk) begin
        if (accept_s) begin
            pd_r[0] <= req_err_s ? {INSTR_W{1'b0}} : mem_r[rd_idx_s];
            pe_r[0] <= req_err_s;
        end
        for (int i = 1; i < READ_LAT; i++) begin
            pd_r[i] <= pd_r[i-1];
            pe_r[i] <= pe_r[i-1];
        end
    end

    // Response FIFO storage; the last pipeline stage writes at the tail
    always_ff @(posedge clk) begin
        if (push_s) begin
            fd_r[wr_ptr_r] <= pd_r[READ_LAT-1];
            fe_r[wr_ptr_r] <= pe_r[READ_LAT-1];
        end
    end

    // Next FIFO count and next total occupancy (pipeline plus FIFO) for the credit check
    always_comb begin
        count_next_s = count_r;
        if (push_s && !pop_s) begin
            count_next_s = count_r + CW'(1);
        end else if (!push_s && pop_s) begin
            count_next_s = count_r - CW'(1);
        end else begin
            count_next_s = count_r;
        end
        occ_next_s = OW'(count_next_s);
        for (int i = 0; i < READ_LAT - 1; i++) begin
            if (pv_r[i]) begin
                occ_next_s = occ_next_s + OW'(1);
            end else begin
                occ_next_s = occ_next_s;
            end
        end
        if (accept_s) begin
            occ_next_s = occ_next_s + OW'(1);
        end else begin
            occ_next_s = occ_next_s;
        end
    end

    // Control state: pipeline valids, FIFO pointers and count, credit-based ready, fetch counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pv_r        <= {READ_LAT{1'b0}};
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            ready_r     <= 1'b0;
            fetch_cnt_r <= 32'd0;
        end else begin
            pv_r[0] <= accept_s;
            for (int i = 1; i < READ_LAT; i++) begin
                pv_r[i] <= pv_r[i-1];
            end
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r <= count_next_s;
            // Registered from next-state values, so a pop frees its credit one cycle later
            ready_r <= occ_next_s < OW'(RSP_DEPTH);
            if (accept_s && fetch_cnt_r != 32'hFFFF_FFFF) begin
                fetch_cnt_r <= fetch_cnt_r + 32'd1;
            end
        end
    end

    assign req_ready = ready_r;
    assign rsp_valid = rsp_valid_s;
    assign rsp_instr = rsp_valid_s ? fd_r[rd_ptr_r] : {INSTR_W{1'b0}};
    assign rsp_err   = rsp_valid_s ? fe_r[rd_ptr_r] : 1'b0;
    assign fetch_cnt = fetch_cnt_r;

    // Usage checks on the fetch address and on the program-load port
    a_req_addr_known : assert property (@(posedge clk) disable iff (reset)
        req_valid |-> !$isunknown(req_addr))
        else $error("req_valid with unknown req_addr");

    a_no_prog_in_reset : assert property (@(posedge clk) !(prog_we && reset))
        else $error("prog_we asserted during reset");

endmodule
